// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline hazard control, run-state FSM and perf counters
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             dbg_req_i,
    output logic             dbg_ack_o,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             set_cc_o,
    output logic             halted_o,
    output logic [2:0]       cpu_stat_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic lu_raw;
    logic lu;
    logic ret_h;
    logic mis;
    logic exc;
    logic w_exc;

    // Hazard detection; a mispredict owns the E slot, so it suppresses load/use
    always_comb begin
        lu_raw = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                 (E_dstM_i != RNONE) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        mis    = (E_icode_i == IJXX) && !e_Cnd_i;
        lu     = lu_raw && !mis;
        ret_h  = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        w_exc  = (W_stat_i != SAOK);
        exc    = (m_stat_i != SAOK) || w_exc;
    end

    // Run-state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: halt beats freeze; freeze only at a hazard-free boundary
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_exc) begin
                    state_nxt = ST_HALTED;
                end else if (dbg_req_i && !lu && !ret_h && !mis && !exc) begin
                    state_nxt = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                if (!dbg_req_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    // Stage controls decoded from state and hazards; reset forces nops into D/E/M
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        W_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        set_cc_o   = 1'b0;
        dbg_ack_o  = 1'b0;
        halted_o   = 1'b0;
        if (!rst_n_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    F_stall_o  = lu || ret_h;
                    D_stall_o  = lu;
                    D_bubble_o = mis || (!lu && ret_h);
                    E_bubble_o = mis || lu;
                    M_bubble_o = exc;
                    W_stall_o  = w_exc;
                    set_cc_o   = (E_icode_i == IOPQ) && !exc;
                end
                ST_FREEZE: begin
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_stall_o = 1'b1;
                    M_stall_o = 1'b1;
                    W_stall_o = 1'b1;
                    dbg_ack_o = 1'b1;
                end
                ST_HALTED: begin
                    F_stall_o  = 1'b1;
                    D_stall_o  = 1'b1;
                    E_stall_o  = 1'b1;
                    M_stall_o  = 1'b1;
                    W_stall_o  = 1'b1;
                    M_bubble_o = 1'b1;
                    halted_o   = 1'b1;
                end
                default: begin
                    F_stall_o = 1'b0;
                end
            endcase
        end
    end

    // Architectural status captured on the edge that enters HALTED
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpu_stat_o <= SAOK;
        end else if ((state_q == ST_RUN) && w_exc) begin
            cpu_stat_o <= W_stat_i;
        end
    end

    // Saturating performance counters, advancing only while running
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_o  <= '0;
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else if (state_q == ST_RUN) begin
            if (cycle_cnt_o != CNT_MAX) begin
                cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
            end
            if (F_stall_o && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
            if ((D_bubble_o || E_bubble_o) && (bubble_cnt_o != CNT_MAX)) begin
                bubble_cnt_o <= bubble_cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd2;
    localparam logic [2:0] SHLT    = 3'd4;

    // {F,D,E,M,W stall, D,E,M bubble, set_cc, dbg_ack, halted}
    localparam logic [10:0] C_IDLE   = 11'b00000_000_000;
    localparam logic [10:0] C_RESET  = 11'b00000_111_000;
    localparam logic [10:0] C_LU     = 11'b11000_010_000;
    localparam logic [10:0] C_RET    = 11'b10000_100_000;
    localparam logic [10:0] C_MIS    = 11'b00000_110_000;
    localparam logic [10:0] C_SETCC  = 11'b00000_000_100;
    localparam logic [10:0] C_MEXC   = 11'b00000_001_000;
    localparam logic [10:0] C_WEXC   = 11'b00001_001_000;
    localparam logic [10:0] C_FREEZE = 11'b11111_000_010;
    localparam logic [10:0] C_HALT   = 11'b11111_001_001;

    logic       clk_i     = 1'b0;
    logic       rst_n_i   = 1'b0;
    logic [3:0] D_icode_i = INOP;
    logic [3:0] d_srcA_i  = RNONE;
    logic [3:0] d_srcB_i  = RNONE;
    logic [3:0] E_icode_i = INOP;
    logic [3:0] E_dstM_i  = RNONE;
    logic       e_Cnd_i   = 1'b0;
    logic [3:0] M_icode_i = INOP;
    logic [2:0] m_stat_i  = SAOK;
    logic [2:0] W_stat_i  = SAOK;
    logic       dbg_req_i = 1'b0;

    logic        dbg_ack_o, F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o;
    logic        D_bubble_o, E_bubble_o, M_bubble_o, set_cc_o, halted_o;
    logic [2:0]  cpu_stat_o;
    logic [31:0] cycle_cnt_o, stall_cnt_o, bubble_cnt_o;

    logic        s_dbg_ack, s_F_stall, s_D_stall, s_E_stall, s_M_stall, s_W_stall;
    logic        s_D_bubble, s_E_bubble, s_M_bubble, s_set_cc, s_halted;
    logic [2:0]  s_cpu_stat;
    logic [3:0]  s_cycle_cnt, s_stall_cnt, s_bubble_cnt;

    logic [10:0] ctl;
    assign ctl = {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o,
                  D_bubble_o, E_bubble_o, M_bubble_o, set_cc_o, dbg_ack_o, halted_o};

    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_run = 1'b0;
    logic [31:0] exp_cyc = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_bub = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.CNT_W(32)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
        .M_icode_i(M_icode_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
        .dbg_req_i(dbg_req_i), .dbg_ack_o(dbg_ack_o),
        .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .E_stall_o(E_stall_o),
        .M_stall_o(M_stall_o), .W_stall_o(W_stall_o),
        .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o), .M_bubble_o(M_bubble_o),
        .set_cc_o(set_cc_o), .halted_o(halted_o), .cpu_stat_o(cpu_stat_o),
        .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    pipe_ctrl #(.CNT_W(4)) u_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .D_icode_i(D_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
        .M_icode_i(M_icode_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
        .dbg_req_i(dbg_req_i), .dbg_ack_o(s_dbg_ack),
        .F_stall_o(s_F_stall), .D_stall_o(s_D_stall), .E_stall_o(s_E_stall),
        .M_stall_o(s_M_stall), .W_stall_o(s_W_stall),
        .D_bubble_o(s_D_bubble), .E_bubble_o(s_E_bubble), .M_bubble_o(s_M_bubble),
        .set_cc_o(s_set_cc), .halted_o(s_halted), .cpu_stat_o(s_cpu_stat),
        .cycle_cnt_o(s_cycle_cnt), .stall_cnt_o(s_stall_cnt), .bubble_cnt_o(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Check stage controls mid-cycle, then clock once and advance the counter model
    task automatic vec(input string tag, input logic [10:0] e);
        #1;
        chk(tag, {21'b0, ctl}, {21'b0, e});
        @(posedge clk_i);
        #1;
        if (exp_run) begin
            exp_cyc++;
            if (e[10]) exp_stall++;
            if (e[5] | e[4]) exp_bub++;
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cycle"}, cycle_cnt_o, exp_cyc);
        chk({tag, "_stall"}, stall_cnt_o, exp_stall);
        chk({tag, "_bubble"}, bubble_cnt_o, exp_bub);
    endtask

    task automatic nop_in();
        D_icode_i = INOP;  d_srcA_i = RNONE; d_srcB_i = RNONE;
        E_icode_i = INOP;  E_dstM_i = RNONE; e_Cnd_i  = 1'b0;
        M_icode_i = INOP;  m_stat_i = SAOK;  W_stat_i = SAOK;
    endtask

    initial begin
        // reset held low
        @(posedge clk_i); #1;
        vec("reset_ctl", C_RESET);
        chk_cnt("reset");
        chk("reset_stat", {29'b0, cpu_stat_o}, {29'b0, SAOK});
        chk("reset_sat_cycle", {28'b0, s_cycle_cnt}, 32'd0);

        // release and idle: 32-bit counter counts 20, 4-bit counter saturates at 15
        rst_n_i = 1'b1;
        exp_run = 1'b1;
        for (int i = 0; i < 20; i++) vec("idle", C_IDLE);
        chk("idle_cycle20", cycle_cnt_o, 32'd20);
        chk("sat_cycle15", {28'b0, s_cycle_cnt}, 32'd15);
        chk_cnt("idle");

        // load/use: mrmovq -> %rax, consumer reads %rax
        nop_in(); E_icode_i = IMRMOVQ; E_dstM_i = 4'h0; D_icode_i = IOPQ;
        d_srcA_i = 4'h0; d_srcB_i = 4'h3;
        vec("lu_srcA", C_LU);
        nop_in(); E_icode_i = IOPQ;
        vec("opq_setcc", C_SETCC);
        nop_in(); E_icode_i = IPOPQ; E_dstM_i = 4'h4; d_srcB_i = 4'h4;
        vec("lu_popq_srcB", C_LU);
        nop_in(); E_icode_i = IMRMOVQ; E_dstM_i = RNONE; d_srcA_i = RNONE;
        vec("lu_rnone", C_IDLE);
        nop_in(); E_icode_i = IIRMOVQ; E_dstM_i = 4'h0; d_srcA_i = 4'h0;
        vec("no_lu_irmov", C_IDLE);

        // ret walking D, E, M
        nop_in(); D_icode_i = IRET; vec("ret_D", C_RET);
        nop_in(); E_icode_i = IRET; vec("ret_E", C_RET);
        nop_in(); M_icode_i = IRET; vec("ret_M", C_RET);
        nop_in(); vec("ret_done", C_IDLE);

        // load/use together with ret: load/use wins the D slot
        nop_in(); E_icode_i = IMRMOVQ; E_dstM_i = 4'h0; d_srcA_i = 4'h0; D_icode_i = IRET;
        vec("lu_ret", C_LU);

        // branch mispredict vs taken
        nop_in(); E_icode_i = IJXX; e_Cnd_i = 1'b0; vec("jxx_mis", C_MIS);
        e_Cnd_i = 1'b1; vec("jxx_taken", C_IDLE);

        // memory exception blocks cc update
        nop_in(); E_icode_i = IOPQ; m_stat_i = SADR; vec("m_exc", C_MEXC);
        nop_in();
        chk("hz_stall6", stall_cnt_o, 32'd6);
        chk("hz_bubble7", bubble_cnt_o, 32'd7);
        chk_cnt("hazards");

        // debug request during a ret: ack waits until the ret leaves M
        dbg_req_i = 1'b1;
        nop_in(); D_icode_i = IRET; vec("dbg_ret_D", C_RET);
        nop_in(); E_icode_i = IRET; vec("dbg_ret_E", C_RET);
        nop_in(); M_icode_i = IRET; vec("dbg_ret_M", C_RET);
        nop_in(); vec("dbg_clean", C_IDLE);
        exp_run = 1'b0;
        vec("freeze1", C_FREEZE);
        E_icode_i = IOPQ;
        vec("freeze2", C_FREEZE);
        nop_in();
        chk_cnt("frozen");
        dbg_req_i = 1'b0;
        vec("unfreeze", C_FREEZE);
        exp_run = 1'b1;
        vec("run_again", C_IDLE);
        chk_cnt("run_again");

        // asynchronous reset in the middle of a freeze
        dbg_req_i = 1'b1;
        vec("pre_freeze", C_IDLE);
        exp_run = 1'b0;
        vec("freeze3", C_FREEZE);
        #2;
        rst_n_i = 1'b0;
        #1;
        exp_cyc = 0; exp_stall = 0; exp_bub = 0;
        chk("arst_ctl", {21'b0, ctl}, {21'b0, C_RESET});
        chk_cnt("arst");
        chk("arst_sat_cycle", {28'b0, s_cycle_cnt}, 32'd0);
        dbg_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        exp_run = 1'b1;
        vec("post_reset", C_IDLE);
        chk_cnt("post_reset");

        // halt on W status
        nop_in(); E_icode_i = IRET; W_stat_i = SHLT;
        vec("halt_edge", C_WEXC | 11'b10000_100_000);
        exp_run = 1'b0;
        nop_in();
        vec("halted", C_HALT);
        chk("halt_stat", {29'b0, cpu_stat_o}, {29'b0, SHLT});
        dbg_req_i = 1'b1; E_icode_i = IOPQ;
        vec("halted_dbg", C_HALT);
        dbg_req_i = 1'b0; nop_in();
        chk_cnt("halted_frozen");
        chk("halt_cycle2", cycle_cnt_o, 32'd2);

        // only reset leaves HALTED
        rst_n_i = 1'b0;
        #1;
        chk("halt_rst_ctl", {21'b0, ctl}, {21'b0, C_RESET});
        chk("halt_rst_stat", {29'b0, cpu_stat_o}, {29'b0, SAOK});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
